mtc_ppa_ptr_reg: RTL
====================

// Module: mtc_ppa_ptr_reg
// PURPOSE
//  Registered successor of the mTC-PPA high-priority-pointer mux: selects the highest-indexed active grant
//  lane, rotates its grant one position left with wrap-around, and commits the result as the round-robin pointer.
//  Sits between the mTC-PPA grant stage and the request-masking stage. Valid/ready on both sides.
//  Also reports the number of grants issued per accepted beat.
// PARAMETERS
//  WIDTH_N   8   request vector width, >= 2
//  AMOUNT_M  2   max simultaneous grants (lanes), >= 1
//  PTR_RST   1   one-hot reset value of committed pointer (WIDTH_N bits; default = bit 0)
// PORTS
//  clk                 in   1                    clock
//  reset_n             in   1                    async active-low reset
//  in_gnt_i            in   AMOUNT_M x WIDTH_N   per-lane one-hot grant (th')
//  in_gntss_i          in   AMOUNT_M x WIDTH_N   per-lane thermometer prefix (th'')
//  in_gnt_vld_i        in   1                    input beat valid
//  in_gnt_rdy_o        out  1                    input beat ready
//  out_ptr_next_o      out  WIDTH_N              next pointer for this beat (one-hot, registered)
//  out_gnt_cnt_o       out  $clog2(AMOUNT_M+1)   number of lanes with selector set
//  out_hold_o          out  1                    1 = no lane selected, pointer unchanged
//  out_ptr_next_vld_o  out  1                    output beat valid
//  out_ptr_next_rdy_i  in   1                    output beat ready
//  ptr_o               out  WIDTH_N              committed pointer, always valid
// BEHAVIOUR
//  - Reset (async assert, sync release): out_ptr_next_vld_o=0, out_ptr_next_o=0, out_gnt_cnt_o=0,
//    out_hold_o=0, ptr_o=PTR_RST; in_gnt_rdy_o=1 after release.
//  - selector[i] = in_gntss_i[i][WIDTH_N-1]. j = highest i with selector[i]=1.
//  - rot = {in_gnt_i[j][WIDTH_N-2:0], in_gnt_i[j][WIDTH_N-1]} (circular; MSB grant wraps to bit 0).
//  - cnt = popcount(selector), unsigned, width $clog2(AMOUNT_M+1); no saturation needed.
//  - Accept = in_gnt_vld_i & in_gnt_rdy_o. On accept:
//    selector!=0: out_ptr_next_o<=rot, ptr_o<=rot, out_hold_o<=0;
//    selector==0: out_ptr_next_o<=ptr_o, ptr_o unchanged, out_hold_o<=1; out_gnt_cnt_o<=cnt; vld<=1.
//  - Latency: 1 cycle accept -> out_ptr_next_vld_o. ptr_o updates same edge as output register.
//  - Output stays stable while vld & !rdy. vld clears on handshake with no new accept.
//  - Without skid: in_gnt_rdy_o = !out_ptr_next_vld_o | out_ptr_next_rdy_i (full throughput, comb path).
//  - Simultaneous out handshake + accept: new beat loaded, vld stays 1, no bubble.
//  - Non-one-hot in_gnt_i[j]: rotated as-is, no check (see assertions in TESTING).
//  - Reset mid-beat: beat discarded, ptr_o returns to PTR_RST.
// CONFIGURATION
//  MTC_PPA_PTR_SKID_EN defined: 2-entry skid buffer on output; in_gnt_rdy_o is a flop (= skid not full).
//    Latency still 1 cycle when empty; sustains 1 beat/cycle. ptr_o commits on accept (input side),
//    so back-to-back beats chain on the newest pointer.
//  Undefined: single output register, comb ready as above.
// STRUCTURE
//  - Package mtc_ppa_pkg: function rotl1 (circular one-hot rotate), function popcount,
//    localparam CNT_W = $clog2(AMOUNT_M+1), beat struct typedef {ptr, cnt, hold}.
//  - Sub-module mtc_ppa_skid_buf (parametrised on beat struct width), instantiated only under macro.
//  - Lane select: priority scan from AMOUNT_M-1 downward, comb.
// TESTING (WIDTH_N=8, AMOUNT_M=2, both macro settings)
//  1. Reset: ptr_o=8'h01, vld=0; release, rdy=1 -> no output until first accept.
//  2. gnt[1]=8'h10, gntss[1]=8'hF0, gntss[0]=8'h80 -> next cycle ptr_next=8'h20, cnt=2, hold=0, ptr_o=8'h20.
//  3. Wrap: gnt[1]=8'h80, gntss[1]=8'h80 -> ptr_next=8'h01, cnt=1.
//  4. Only lane0: gnt[0]=8'h04, gntss[0]=8'hFC, gntss[1]=0 -> ptr_next=8'h08, cnt=1.
//  5. No selector: gntss=0 -> hold=1, ptr_next=current ptr_o, cnt=0, ptr_o unchanged.
//  6. Backpressure: out_rdy=0 for 3 cycles with stream of beats -> output stable, no loss/duplication,
//     in order; skid build: rdy drops after 2 beats buffered. Assert one-hot of ptr_o each cycle.

Source files
------------

// File: rtl/mtc_ppa_ptr_reg_pkg.sv
// ============================================================================
//  Module   : mtc_ppa_pkg
//  Brief    : Shared types and helpers for the mTC-PPA pointer register.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package mtc_ppa_pkg;

    localparam int PPA_WIDTH_N  = 8;
    localparam int PPA_AMOUNT_M = 2;
    localparam int CNT_W        = $clog2(PPA_AMOUNT_M + 1);
    localparam int MAX_W        = 64;

    typedef struct packed {
        logic [PPA_WIDTH_N-1:0] ptr;
        logic [CNT_W-1:0]       cnt;
        logic                   hold;
    } ppa_beat_t;

    // Rotate the low w bits of v left by one; bit w-1 wraps to bit 0.
    function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] wrap;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        wrap = (v >> (w - 1)) & MAX_W'(1);
        return ((v << 1) | wrap) & mask;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mtc_ppa_ptr_reg_if.sv
// ============================================================================
//  Module   : mtc_ppa_ptr_reg_if
//  Brief    : Grant-in / pointer-out handshake bundle of mtc_ppa_ptr_reg.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface mtc_ppa_ptr_reg_if #(
    parameter int WIDTH_N  = 8,
    parameter int AMOUNT_M = 2
);
    logic [AMOUNT_M-1:0][WIDTH_N-1:0]   in_gnt_i;
    logic [AMOUNT_M-1:0][WIDTH_N-1:0]   in_gntss_i;
    logic                               in_gnt_vld_i;
    logic                               in_gnt_rdy_o;
    logic [WIDTH_N-1:0]                 out_ptr_next_o;
    logic [$clog2(AMOUNT_M+1)-1:0]      out_gnt_cnt_o;
    logic                               out_hold_o;
    logic                               out_ptr_next_vld_o;
    logic                               out_ptr_next_rdy_i;
    logic [WIDTH_N-1:0]                 ptr_o;

    modport master (
        output in_gnt_i, in_gntss_i, in_gnt_vld_i, out_ptr_next_rdy_i,
        input  in_gnt_rdy_o, out_ptr_next_o, out_gnt_cnt_o, out_hold_o,
               out_ptr_next_vld_o, ptr_o
    );

    modport slave (
        input  in_gnt_i, in_gntss_i, in_gnt_vld_i, out_ptr_next_rdy_i,
        output in_gnt_rdy_o, out_ptr_next_o, out_gnt_cnt_o, out_hold_o,
               out_ptr_next_vld_o, ptr_o
    );
endinterface

`default_nettype wire

// File: rtl/mtc_ppa_ptr_reg_skid.sv
// ============================================================================
//  Module   : mtc_ppa_skid_buf
//  Brief    : Two-entry output skid buffer with registered input ready.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mtc_ppa_skid_buf #(
    parameter int BEAT_W = 11
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic [BEAT_W-1:0] in_data,
    input  wire logic              in_vld,
    output logic                   in_rdy,
    output logic [BEAT_W-1:0]      out_data,
    output logic                   out_vld,
    input  wire logic              out_rdy
);
    logic [BEAT_W-1:0] r_mem [2];
    logic              r_wr;
    logic              r_rd;
    logic [1:0]        r_count;
    logic              r_in_rdy;

    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_count_nxt;

    assign w_push      = in_vld & r_in_rdy;
    assign w_pop       = out_vld & out_rdy;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_count  <= 2'd0;
            r_in_rdy <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= in_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            r_count  <= w_count_nxt;
            // Ready is looked ahead one cycle so it can be a plain flop.
            r_in_rdy <= (w_count_nxt != 2'd2);
        end
    end

    assign in_rdy   = r_in_rdy;
    assign out_vld  = (r_count != 2'd0);
    assign out_data = r_mem[r_rd];

endmodule

`default_nettype wire

// File: rtl/mtc_ppa_ptr_reg.sv
// ============================================================================
//  Module   : mtc_ppa_ptr_reg
//  Brief    : Registered mTC-PPA pointer successor: picks the highest active
//             lane, rotates its grant left by one and commits it as pointer.
//             MTC_PPA_PTR_SKID_EN adds a 2-entry output skid buffer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mtc_ppa_ptr_reg
    import mtc_ppa_pkg::*;
#(
    parameter int                 WIDTH_N  = 8,
    parameter int                 AMOUNT_M = 2,
    parameter logic [WIDTH_N-1:0] PTR_RST  = WIDTH_N'(1)
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    mtc_ppa_ptr_reg_if.slave bus
);
    localparam int c_CNT_W  = $clog2(AMOUNT_M + 1);
    localparam int c_BEAT_W = WIDTH_N + c_CNT_W + 1;

    typedef struct packed {
        logic [WIDTH_N-1:0] ptr;
        logic [c_CNT_W-1:0] cnt;
        logic               hold;
    } beat_t;

    logic [AMOUNT_M-1:0] w_selector;
    logic [WIDTH_N-1:0]  w_lane_gnt;
    logic                w_found;
    logic                w_sel_any;
    logic [WIDTH_N-1:0]  w_rot;
    beat_t               w_beat;
    beat_t               w_out;
    logic                w_in_rdy;
    logic                w_accept;
    logic [WIDTH_N-1:0]  r_ptr;

    always_comb begin
        w_selector = '0;
        w_lane_gnt = '0;
        w_found    = 1'b0;
        for (int i = 0; i < AMOUNT_M; i++) begin
            w_selector[i] = bus.in_gntss_i[i][WIDTH_N-1];
        end
        for (int i = AMOUNT_M - 1; i >= 0; i--) begin
            if (w_selector[i] && !w_found) begin
                w_lane_gnt = bus.in_gnt_i[i];
                w_found    = 1'b1;
            end
        end
    end

    assign w_sel_any   = |w_selector;
    assign w_rot       = WIDTH_N'(rotl1(MAX_W'(w_lane_gnt), WIDTH_N));
    assign w_beat.ptr  = w_sel_any ? w_rot : r_ptr;
    assign w_beat.cnt  = c_CNT_W'(popcount(MAX_W'(w_selector)));
    assign w_beat.hold = ~w_sel_any;
    assign w_accept    = bus.in_gnt_vld_i & w_in_rdy;

    // Pointer commits on the input side so consecutive beats chain on it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= PTR_RST;
        end else if (w_accept) begin
            r_ptr <= w_beat.ptr;
        end
    end

`ifdef MTC_PPA_PTR_SKID_EN
    logic [c_BEAT_W-1:0] w_out_data;
    logic                w_out_vld;

    mtc_ppa_skid_buf #(
        .BEAT_W (c_BEAT_W)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (w_beat),
        .in_vld   (bus.in_gnt_vld_i),
        .in_rdy   (w_in_rdy),
        .out_data (w_out_data),
        .out_vld  (w_out_vld),
        .out_rdy  (bus.out_ptr_next_rdy_i)
    );

    assign w_out                  = beat_t'(w_out_data);
    assign bus.out_ptr_next_vld_o = w_out_vld;
`else
    beat_t r_out;
    logic  r_vld;

    assign w_in_rdy = ~r_vld | bus.out_ptr_next_rdy_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
            r_vld <= 1'b0;
        end else if (w_accept) begin
            r_out <= w_beat;
            r_vld <= 1'b1;
        end else if (bus.out_ptr_next_rdy_i) begin
            r_vld <= 1'b0;
        end
    end

    assign w_out                  = r_out;
    assign bus.out_ptr_next_vld_o = r_vld;
`endif

    assign bus.in_gnt_rdy_o   = w_in_rdy;
    assign bus.out_ptr_next_o = w_out.ptr;
    assign bus.out_gnt_cnt_o  = w_out.cnt;
    assign bus.out_hold_o     = w_out.hold;
    assign bus.ptr_o          = r_ptr;

endmodule

`default_nettype wire
